// File: rtl/ag_tcu_dispatch_arbiter_if.sv
// Dispatch-side and core-side handshake bundle for the AG-TCU dispatch arbiter.
// The slave modport is the arbiter; the master modport is the requesters plus core.
interface ag_tcu_dispatch_arbiter_if #(
    parameter int NUM_REQS    = 4,
    parameter int MAX_PENDING = 8,
    parameter int EXE_W       = 64,
    parameter int RES_W       = 64
);
    localparam int CNT_W = $clog2(MAX_PENDING) + 1;

    logic [NUM_REQS-1:0]       req_valid;
    logic [NUM_REQS*EXE_W-1:0] req_data;
    logic [NUM_REQS-1:0]       req_ready;
    logic                      exe_valid;
    logic [EXE_W-1:0]          exe_data;
    logic                      exe_ready;
    logic                      res_valid;
    logic [RES_W-1:0]          res_data;
    logic                      res_ready;
    logic [NUM_REQS-1:0]       rsp_valid;
    logic [RES_W-1:0]          rsp_data;
    logic [NUM_REQS-1:0]       rsp_ready;
    logic [CNT_W-1:0]          pending_cnt;
    logic                      proto_err;

    modport slave (
        input  req_valid, req_data, exe_ready, res_valid, res_data, rsp_ready,
        output req_ready, exe_valid, exe_data, res_ready, rsp_valid, rsp_data,
               pending_cnt, proto_err
    );

    modport master (
        output req_valid, req_data, exe_ready, res_valid, res_data, rsp_ready,
        input  req_ready, exe_valid, exe_data, res_ready, rsp_valid, rsp_data,
               pending_cnt, proto_err
    );
endinterface

// File: rtl/ag_tcu_dispatch_arbiter.sv
// Round-robin arbiter sharing one AG-TCU core among NUM_REQS requesters, with an
// in-order tag FIFO that steers each core result back to its issuing requester.
module ag_tcu_dispatch_arbiter #(
    parameter int NUM_REQS    = 4,
    parameter int MAX_PENDING = 8,
    parameter int EXE_W       = 64,
    parameter int RES_W       = 64
) (
    input  logic                  clk,
    input  logic                  reset_n,
    ag_tcu_dispatch_arbiter_if.slave bus
);
    localparam int IDX_W = $clog2(NUM_REQS);
    localparam int PTR_W = $clog2(MAX_PENDING);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic {
        ST_ARB  = 1'b0,
        ST_LOCK = 1'b1
    } state_t;

    state_t           state, state_nxt;
    logic [IDX_W-1:0] rr_ptr;
    logic [IDX_W-1:0] locked_idx, locked_idx_nxt;
    logic [IDX_W-1:0] rr_grant, grant, head;
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [CNT_W-1:0] count;
    logic [IDX_W-1:0] tag_mem [MAX_PENDING];
    logic             any_req, full, empty;
    logic             exe_fire, res_fire, lock_drop, orphan_res;
    logic             proto_err_q;

    function automatic logic [IDX_W-1:0] rr_pick(input logic [NUM_REQS-1:0] valid,
                                                 input logic [IDX_W-1:0]    ptr);
        logic [IDX_W-1:0] pick;
        logic             found;
        int               idx;
        pick  = ptr;
        found = 1'b0;
        for (int k = 0; k < NUM_REQS; k++) begin
            idx = (int'(ptr) + k) % NUM_REQS;
            if (!found && valid[idx]) begin
                pick  = IDX_W'(idx);
                found = 1'b1;
            end
        end
        return pick;
    endfunction

    function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] g);
        return (int'(g) == NUM_REQS - 1) ? '0 : g + IDX_W'(1);
    endfunction

    assign any_req  = |bus.req_valid;
    assign full     = (count == CNT_W'(MAX_PENDING));
    assign empty    = (count == '0);
    assign rr_grant = rr_pick(bus.req_valid, rr_ptr);
    assign grant    = (state == ST_LOCK) ? locked_idx : rr_grant;

    // No handshake is advertised while reset is held, even with requests pending.
    assign bus.exe_valid = reset_n & any_req & ~full;
    assign bus.exe_data  = bus.req_data[int'(grant)*EXE_W +: EXE_W];
    assign exe_fire      = bus.exe_valid & bus.exe_ready;

    always_comb begin
        bus.req_ready = '0;
        if (reset_n && bus.exe_ready && !full)
            bus.req_ready[grant] = 1'b1;
    end

    assign lock_drop  = (state == ST_LOCK) & ~bus.req_valid[locked_idx];
    assign head       = tag_mem[rd_ptr];
    assign bus.res_ready = ~empty & bus.rsp_ready[head];
    assign bus.rsp_data  = bus.res_data;
    assign res_fire   = bus.res_valid & bus.res_ready;
    assign orphan_res = bus.res_valid & empty;

    always_comb begin
        bus.rsp_valid = '0;
        if (bus.res_valid && !empty)
            bus.rsp_valid[head] = 1'b1;
    end

    // A dropped lock outranks a stall so arbitration restarts from rr_ptr.
    always_comb begin
        state_nxt      = state;
        locked_idx_nxt = locked_idx;
        if (lock_drop) begin
            state_nxt = ST_ARB;
        end else if (exe_fire) begin
            state_nxt = ST_ARB;
        end else if (bus.exe_valid && !bus.exe_ready) begin
            state_nxt      = ST_LOCK;
            locked_idx_nxt = grant;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= ST_ARB;
            locked_idx <= '0;
        end else begin
            state      <= state_nxt;
            locked_idx <= locked_idx_nxt;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rr_ptr      <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            proto_err_q <= 1'b0;
        end else begin
            if (exe_fire) begin
                rr_ptr <= next_idx(grant);
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (res_fire)
                rd_ptr <= rd_ptr + PTR_W'(1);
            case ({exe_fire, res_fire})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
            proto_err_q <= proto_err_q | lock_drop | orphan_res;
        end
    end

    always_ff @(posedge clk) begin
        if (exe_fire)
            tag_mem[wr_ptr] <= grant;
    end

    assign bus.pending_cnt = count;
    assign bus.proto_err   = proto_err_q;
endmodule

// File: tb/tb_ag_tcu_dispatch_arbiter.sv
// Bench for ag_tcu_dispatch_arbiter: vector table plus hand sequences, with a
// queue of expected issuing requesters checked against routed results.
module tb_ag_tcu_dispatch_arbiter;
    localparam int NR = 4;
    localparam int MP = 8;
    localparam int EW = 32;
    localparam int RW = 32;

    typedef struct {
        logic [NR-1:0] req_valid;
        logic          exe_ready;
        logic          res_valid;
        logic [NR-1:0] rsp_ready;
        logic          exp_exe_valid;
        int            exp_grant;
        int            exp_pending;
        logic          exp_err;
    } vec_t;

    logic clk = 1'b0;
    logic reset_n;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   exp_q[$];
    vec_t tbl[$];

    always #5 clk = ~clk;

    ag_tcu_dispatch_arbiter_if #(.NUM_REQS(NR), .MAX_PENDING(MP), .EXE_W(EW), .RES_W(RW)) bus ();

    ag_tcu_dispatch_arbiter #(.NUM_REQS(NR), .MAX_PENDING(MP), .EXE_W(EW), .RES_W(RW)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    function automatic logic [EW-1:0] req_word(input int i);
        return 32'hA5A5_0000 + 32'(i) * 32'h0000_1111;
    endfunction

    function automatic logic [NR-1:0] onehot(input int i);
        return NR'(1) << i;
    endfunction

    function automatic vec_t v(input logic [NR-1:0] rv, input logic er, input logic resv,
                               input logic [NR-1:0] rr, input logic eev, input int g,
                               input int p, input logic e);
        vec_t t;
        t.req_valid = rv;  t.exe_ready = er;      t.res_valid = resv;
        t.rsp_ready = rr;  t.exp_exe_valid = eev; t.exp_grant = g;
        t.exp_pending = p; t.exp_err = e;
        return t;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step(input vec_t t);
        logic [NR-1:0] exp_rsp;
        logic          exp_rr;
        logic [RW-1:0] rd;
        rd            = $urandom;
        bus.req_valid = t.req_valid;
        bus.exe_ready = t.exe_ready;
        bus.res_valid = t.res_valid;
        bus.rsp_ready = t.rsp_ready;
        bus.res_data  = rd;
        #1;
        check("exe_valid", bus.exe_valid, t.exp_exe_valid);
        if (t.exp_exe_valid)
            check("exe_data", bus.exe_data, req_word(t.exp_grant));
        check("req_ready", bus.req_ready,
              (t.exe_ready && t.exp_exe_valid) ? onehot(t.exp_grant) : '0);
        exp_rsp = '0;
        exp_rr  = 1'b0;
        if (exp_q.size() > 0) begin
            if (t.res_valid)
                exp_rsp = onehot(exp_q[0]);
            exp_rr = t.rsp_ready[exp_q[0]];
        end
        check("rsp_valid", bus.rsp_valid, exp_rsp);
        check("res_ready", bus.res_ready, exp_rr);
        if (t.res_valid)
            check("rsp_data", bus.rsp_data, rd);
        if (t.res_valid && exp_rr)
            void'(exp_q.pop_front());
        if (t.exe_ready && t.exp_exe_valid)
            exp_q.push_back(t.exp_grant);
        @(posedge clk);
        #1;
        check("pending_cnt", bus.pending_cnt, t.exp_pending);
        check("proto_err", bus.proto_err, t.exp_err);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Single op, round robin, grant lock with mid-stall intruder.
        tbl.push_back(v(4'b0001, 1, 0, 4'b1111, 1, 0, 1, 0));
        tbl.push_back(v(4'b0000, 0, 1, 4'b1111, 0, 0, 0, 0));
        for (int i = 0; i < 6; i++)
            tbl.push_back(v(4'b1111, 1, 0, 4'b1111, 1, (i + 1) % NR, i + 1, 0));
        for (int i = 0; i < 6; i++)
            tbl.push_back(v(4'b0000, 0, 1, 4'b1111, 0, 0, 5 - i, 0));
        tbl.push_back(v(4'b0100, 0, 0, 4'b1111, 1, 2, 0, 0));
        tbl.push_back(v(4'b0101, 0, 0, 4'b1111, 1, 2, 0, 0));
        tbl.push_back(v(4'b0101, 0, 0, 4'b1111, 1, 2, 0, 0));
        tbl.push_back(v(4'b0101, 1, 0, 4'b1111, 1, 2, 1, 0));
        tbl.push_back(v(4'b0001, 1, 0, 4'b1111, 1, 0, 2, 0));
        tbl.push_back(v(4'b0000, 0, 1, 4'b1111, 0, 0, 1, 0));
        tbl.push_back(v(4'b0000, 0, 1, 4'b1111, 0, 0, 0, 0));

        for (int i = 0; i < NR; i++)
            bus.req_data[i*EW +: EW] = req_word(i);
        reset_n       = 1'b0;
        bus.req_valid = '0;
        bus.exe_ready = 1'b0;
        bus.res_valid = 1'b0;
        bus.res_data  = '0;
        bus.rsp_ready = '0;
        @(posedge clk);
        #1;
        check("rst_exe_valid", bus.exe_valid, 1'b0);
        check("rst_req_ready", bus.req_ready, '0);
        check("rst_res_ready", bus.res_ready, 1'b0);
        check("rst_rsp_valid", bus.rsp_valid, '0);
        check("rst_pending", bus.pending_cnt, 0);
        check("rst_proto_err", bus.proto_err, 1'b0);
        reset_n = 1'b1;

        foreach (tbl[i])
            step(tbl[i]);

        // Fill to MAX_PENDING, then a pop plus request in one cycle must not push.
        for (int i = 0; i < MP; i++)
            step(v(4'b0010, 1, 0, 4'b1111, 1, 1, i + 1, 0));
        step(v(4'b0010, 1, 0, 4'b1111, 0, 0, 8, 0));
        step(v(4'b0010, 1, 1, 4'b1111, 0, 0, 7, 0));
        step(v(4'b0010, 1, 0, 4'b1111, 1, 1, 8, 0));
        for (int i = 0; i < MP; i++)
            step(v(4'b0000, 0, 1, 4'b1111, 0, 0, MP - 1 - i, 0));

        // In-order routing req1, req3, req1 with a held-off result for req3.
        step(v(4'b0010, 1, 0, 4'b1111, 1, 1, 1, 0));
        step(v(4'b1000, 1, 0, 4'b1111, 1, 3, 2, 0));
        step(v(4'b0010, 1, 0, 4'b1111, 1, 1, 3, 0));
        step(v(4'b0000, 0, 1, 4'b1111, 0, 0, 2, 0));
        step(v(4'b0000, 0, 1, 4'b0111, 0, 0, 2, 0));
        step(v(4'b0000, 0, 1, 4'b1111, 0, 0, 1, 0));
        step(v(4'b0000, 0, 1, 4'b1111, 0, 0, 0, 0));

        // Result with nothing in flight, then a stall interrupted by reset.
        step(v(4'b0000, 0, 1, 4'b1111, 0, 0, 0, 1));
        step(v(4'b0001, 1, 0, 4'b1111, 1, 0, 1, 1));
        step(v(4'b0100, 0, 0, 4'b1111, 1, 2, 1, 1));
        bus.req_valid = 4'b0100;
        bus.exe_ready = 1'b0;
        bus.res_valid = 1'b1;
        bus.rsp_ready = 4'b1111;
        #1;
        reset_n = 1'b0;
        #1;
        check("mid_rst_exe_valid", bus.exe_valid, 1'b0);
        check("mid_rst_req_ready", bus.req_ready, '0);
        check("mid_rst_res_ready", bus.res_ready, 1'b0);
        check("mid_rst_rsp_valid", bus.rsp_valid, '0);
        check("mid_rst_pending", bus.pending_cnt, 0);
        check("mid_rst_proto_err", bus.proto_err, 1'b0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        exp_q.delete();

        // After reset the pointer restarts at 0 and the lock is gone.
        step(v(4'b1111, 1, 0, 4'b1111, 1, 0, 1, 0));
        step(v(4'b0100, 0, 0, 4'b1111, 1, 2, 1, 0));
        step(v(4'b0001, 0, 0, 4'b1111, 1, 2, 1, 1));
        step(v(4'b0001, 1, 0, 4'b1111, 1, 0, 2, 1));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/ag_tcu_dispatch_arbiter.md
Name: ag_tcu_dispatch_arbiter

Overview:
- Shares one AG-TCU execution core between NUM_REQS dispatch requesters.
- Round-robin arbitration with grant lock during stalled handshakes.
- Records the issuing requester of every in-flight op in an in-order tag FIFO, because the core retires in order, and routes each core result back to that requester.
- Sits between per-lane dispatch ports and the core's execute/result interface.

Parameters:
- NUM_REQS, 4, number of requesters (2..8).
- MAX_PENDING, 8, maximum ops in flight inside the core; power of two.
- EXE_W, $bits(ag_tcu_exe_t), execute payload width.
- RES_W, $bits(ag_tcu_res_t), result payload width.

Ports:
- clk  in  1  clock.
- reset_n  in  1  asynchronous active-low reset.
- req_valid  in  NUM_REQS  per-requester execute valid.
- req_data  in  NUM_REQS*EXE_W  per-requester execute payload.
- req_ready  out  NUM_REQS  per-requester accept.
- exe_valid  out  1  to core execute valid.
- exe_data  out  EXE_W  to core payload (granted requester's data).
- exe_ready  in  1  core accept.
- res_valid  in  1  core result valid.
- res_data  in  RES_W  core result payload.
- res_ready  out  1  result accept to core.
- rsp_valid  out  NUM_REQS  per-requester result valid.
- rsp_data  out  RES_W  result payload, broadcast to all requesters.
- rsp_ready  in  NUM_REQS  per-requester result accept.
- pending_cnt  out  clog2(MAX_PENDING)+1  ops in flight.
- proto_err  out  1  sticky error flag.

Behaviour:
- Reset (reset_n low, async): rr_ptr=0, lock=0, locked_idx=0, tag FIFO empty, pending_cnt=0, proto_err=0. All outputs derived from this state are therefore low: exe_valid, req_ready, res_ready, rsp_valid.
- Grant when lock=0: first requester with req_valid set, scanning from rr_ptr upward modulo NUM_REQS.
- Grant when lock=1: locked_idx.
- exe_valid = (any req_valid) & !full. exe_data = req_data of the granted requester. Zero-cycle combinational path.
- req_ready[i] = (i==grant) & exe_ready & !full. All other requesters see 0.
- Execute fire (exe_valid & exe_ready):
  - push grant index into the tag FIFO;
  - rr_ptr <= grant+1 (mod NUM_REQS);
  - lock <= 0.
- Stall (exe_valid & !exe_ready): lock <= 1 and locked_idx <= grant. exe_data and the grant then stay stable until fire, regardless of other req_valid changes.
- Requesters must hold req_valid/req_data until accepted.
- If the locked requester drops req_valid anyway:
  - proto_err <= 1;
  - lock <= 0;
  - arbitration resumes from rr_ptr the next cycle.
- Full = (pending_cnt == MAX_PENDING). While full, exe_valid=0 even if a pop occurs in the same cycle; there is no push bypass.
- Result routing uses head = tag FIFO head index:
  - rsp_valid[head] = res_valid & !empty; all other bits 0;
  - rsp_data = res_data;
  - res_ready = !empty & rsp_ready[head].
- Result fire (res_valid & res_ready) pops the tag FIFO.
- res_valid while empty: res_ready=0, proto_err <= 1. The result is not consumed.
- pending_cnt: +1 on push only, -1 on pop only, unchanged on simultaneous push and pop.
- FIFO pointers wrap modulo MAX_PENDING.
- proto_err clears only on reset.

Test Plan:
- Single-requester op: req_valid=0001, exe_ready=1 → exe_data=req0, req_ready=0001, pending_cnt 0→1. Then res_valid → rsp_valid=0001, pending_cnt→0.
- Round-robin fairness: all four req_valid held, exe_ready=1 → grant order 0,1,2,3,0,1 on consecutive cycles.
- Grant lock: only req2 valid and exe_ready=0 for 3 cycles, while req0 asserts mid-stall → exe_data stays req2. Fire on cycle 4 → next grant is req3 if valid, else req0.
- Full back-pressure: 8 fires with res_valid=0 → pending_cnt=8, exe_valid=0. A pop and new request in the same cycle → no push that cycle; push occurs the next cycle.
- In-order routing: issue sequence req1,req3,req1, then 3 results with rsp_ready all 1 → rsp_valid 0010, 1000, 0010. Holding rsp_ready[3]=0 on the second result stalls res_ready.
- Errors and reset: res_valid with empty FIFO → res_ready=0, proto_err=1. Drop reset_n mid-stall → all outputs 0 immediately, pending_cnt=0, rr_ptr=0.
